wc_accum_array: RTL

Parametrised read-modify-write accumulator array for the word-count datapath. Each accepted update adds an increment to a per-address counter and overwrites a per-address tag. Updates are fully pipelined, one per cycle, with hazard forwarding for back-to-back hits on the same address. An automatic clear sweep, a host-triggered clear sweep and a coherent read-out port are included. It sits between the hash/lookup stage (update source) and the result drain logic (read-out).

---
 rtl/wc_accum_pkg.sv | 25 ++
 rtl/wc_accum_ram.sv | 29 ++
 rtl/wc_accum_array.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/wc_accum_pkg.sv
// Shared types for the word-count accumulator array.
// Optional feature: define WC_ACCUM_SATURATE_EN for saturating counters.
package wc_accum_pkg;

    localparam int FWD_DEPTH  = 2;
    localparam int MAX_ADDR_W = 32;
    localparam int MAX_INC_W  = 64;
    localparam int MAX_TAG_W  = 64;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        CLEAR
    } state_t;

    // Fields are sized for the widest supported build; upper bits stay zero.
    typedef struct packed {
        logic                  valid;
        logic                  is_read;
        logic [MAX_ADDR_W-1:0] addr;
        logic [MAX_INC_W-1:0]  inc;
        logic [MAX_TAG_W-1:0]  tag;
    } stage_t;

endpackage

// File: rtl/wc_accum_ram.sv
// Simple dual-port RAM, one read and one write port, read-first,
// one cycle read latency.
module wc_accum_ram
    import wc_accum_pkg::*;
#(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

endmodule

// File: rtl/wc_accum_array.sv
// Pipelined read-modify-write accumulator array with forwarding and clear sweep.
// Define WC_ACCUM_SATURATE_EN to saturate counters instead of wrapping.
module wc_accum_array
    import wc_accum_pkg::*;
#(
    parameter int ADDR_WIDTH  = 14,
    parameter int COUNT_WIDTH = 32,
    parameter int TAG_WIDTH   = 32,
    parameter int INC_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    output logic                   busy,
    input  logic                   upd_valid,
    output logic                   upd_ready,
    input  logic [ADDR_WIDTH-1:0]  upd_addr,
    input  logic [INC_WIDTH-1:0]   upd_inc,
    input  logic [TAG_WIDTH-1:0]   upd_tag,
    input  logic                   rd_req,
    input  logic [ADDR_WIDTH-1:0]  rd_addr,
    output logic                   rd_valid,
    output logic [COUNT_WIDTH-1:0] rd_count,
    output logic [TAG_WIDTH-1:0]   rd_tag
);

    localparam int DATA_WIDTH = TAG_WIDTH + COUNT_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    typedef struct packed {
        logic                   valid;
        logic [ADDR_WIDTH-1:0]  addr;
        logic [COUNT_WIDTH-1:0] count;
        logic [TAG_WIDTH-1:0]   tag;
    } wb_t;

    state_t                 state;
    logic [ADDR_WIDTH-1:0]  sweep_ptr;
    logic                   drain_cnt;
    stage_t                 s1;
    wb_t                    hist [FWD_DEPTH];
    logic                   rd_acc;
    logic                   upd_acc;
    logic                   ram_re;
    logic                   ram_we;
    logic [ADDR_WIDTH-1:0]  ram_raddr;
    logic [ADDR_WIDTH-1:0]  ram_waddr;
    logic [DATA_WIDTH-1:0]  ram_rdata;
    logic [DATA_WIDTH-1:0]  ram_wdata;
    logic [COUNT_WIDTH-1:0] base_count;
    logic [TAG_WIDTH-1:0]   base_tag;
    logic [COUNT_WIDTH:0]   sum_ext;
    logic [COUNT_WIDTH-1:0] new_count;
    logic                   unused_bits;

    assign upd_ready = (state == IDLE) && !rd_req && !clear;
    assign rd_acc    = (state == IDLE) && rd_req;
    assign upd_acc   = upd_valid && upd_ready;

    assign ram_re    = rd_acc || upd_acc;
    assign ram_raddr = rd_acc ? rd_addr : upd_addr;
    assign ram_we    = (state == CLEAR) || hist[0].valid;
    assign ram_waddr = (state == CLEAR) ? sweep_ptr : hist[0].addr;
    assign ram_wdata = (state == CLEAR) ? '0
                     : {hist[0].tag, hist[0].count};

    wc_accum_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk   (clk),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_rdata),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= CLEAR;
            sweep_ptr <= '0;
            drain_cnt <= 1'b0;
            busy      <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (clear) begin
                        state     <= DRAIN;
                        drain_cnt <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                DRAIN: begin
                    drain_cnt <= 1'b1;
                    if (drain_cnt) begin
                        state     <= CLEAR;
                        sweep_ptr <= '0;
                    end
                end
                CLEAR: begin
                    sweep_ptr <= sweep_ptr + 1'b1;
                    if (sweep_ptr == LAST_ADDR) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Oldest entry first so the most recent matching update wins.
    always_comb begin
        base_count = ram_rdata[COUNT_WIDTH-1:0];
        base_tag   = ram_rdata[DATA_WIDTH-1:COUNT_WIDTH];
        for (int i = FWD_DEPTH - 1; i >= 0; i--) begin
            if (hist[i].valid &&
                hist[i].addr == s1.addr[ADDR_WIDTH-1:0]) begin
                base_count = hist[i].count;
                base_tag   = hist[i].tag;
            end
        end
    end

    assign sum_ext = {1'b0, base_count}
                   + (COUNT_WIDTH+1)'(s1.inc[INC_WIDTH-1:0]);

`ifdef WC_ACCUM_SATURATE_EN
    assign new_count = sum_ext[COUNT_WIDTH] ? '1
                     : sum_ext[COUNT_WIDTH-1:0];
`else
    assign new_count = sum_ext[COUNT_WIDTH-1:0];
`endif

    assign unused_bits = ^{s1, sum_ext};

    always_ff @(posedge clk) begin
        if (reset) begin
            s1       <= '0;
            rd_valid <= 1'b0;
            rd_count <= '0;
            rd_tag   <= '0;
            for (int i = 0; i < FWD_DEPTH; i++) begin
                hist[i] <= '0;
            end
        end else begin
            s1.valid   <= upd_acc || rd_acc;
            s1.is_read <= rd_acc;
            s1.addr    <= MAX_ADDR_W'(ram_raddr);
            s1.inc     <= MAX_INC_W'(upd_inc);
            s1.tag     <= MAX_TAG_W'(upd_tag);

            hist[0] <= '{
                valid: s1.valid && !s1.is_read,
                addr:  s1.addr[ADDR_WIDTH-1:0],
                count: new_count,
                tag:   s1.tag[TAG_WIDTH-1:0]
            };
            for (int i = 1; i < FWD_DEPTH; i++) begin
                hist[i] <= hist[i-1];
            end

            rd_valid <= s1.valid && s1.is_read;
            if (s1.valid && s1.is_read) begin
                rd_count <= base_count;
                rd_tag   <= base_tag;
            end
        end
    end

endmodule
